// File: rtl/fifo_array_pkg.sv
// ============================================================================
// Module   : fifo_array_pkg
// Brief    : Shared state encoding and lane sizing for the FIFO array reader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_array_pkg;

    // Each FIFO lane carries a double-width accumulator result.
    localparam int LANE_MULT = 2;

    function automatic int lane_width(input int data_width);
        return data_width * LANE_MULT;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_READ = 3'd2,
        ST_WAIT = 3'd3,
        ST_SEND = 3'd4,
        ST_DONE = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/fifo_array_reader.sv
// ============================================================================
// Module   : fifo_array_reader
// Brief    : Drains a FIFO array row by row and serializes each row lane-first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_array_reader
    import fifo_array_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int SYSTOLIC_SIZE = 16,
    parameter int NUM_MODULES   = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic                                rd_clr,
    output logic                                rd_en,
    input  logic [NUM_MODULES*DATA_WIDTH*2-1:0] fifo_data,
    output logic [DATA_WIDTH*2-1:0]             out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [$clog2(NUM_MODULES)-1:0]      out_col,
    output logic [$clog2(SYSTOLIC_SIZE)-1:0]    out_row,
    output logic                                busy,
    output logic                                done
);

    localparam int LANE_W = lane_width(DATA_WIDTH);
    localparam int COL_W  = $clog2(NUM_MODULES);
    localparam int ROW_W  = $clog2(SYSTOLIC_SIZE);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_MODULES - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(SYSTOLIC_SIZE - 1);

    state_t            state;
    logic [LANE_W-1:0] cap [NUM_MODULES];
    logic [COL_W-1:0]  next_col;

    assign next_col = out_col + COL_W'(1);

    // Outputs are registered, so each branch sets the values the next state presents.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rd_clr    <= 1'b0;
            rd_en     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_col   <= '0;
            out_row   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < NUM_MODULES; i++) begin
                cap[i] <= '0;
            end
        end else begin
            rd_clr <= 1'b0;
            rd_en  <= 1'b0;
            done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_CLR;
                        rd_clr <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                ST_CLR: begin
                    state   <= ST_READ;
                    rd_en   <= 1'b1;
                    out_row <= '0;
                end
                ST_READ: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Row data is on fifo_data now; lane 0 goes straight to the output.
                    for (int i = 0; i < NUM_MODULES; i++) begin
                        cap[i] <= fifo_data[i*LANE_W +: LANE_W];
                    end
                    out_data  <= fifo_data[LANE_W-1:0];
                    out_col   <= '0;
                    out_valid <= 1'b1;
                    state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (out_ready) begin
                        if (out_col != LAST_COL) begin
                            out_col  <= next_col;
                            out_data <= cap[next_col];
                        end else begin
                            out_valid <= 1'b0;
                            if (out_row != LAST_ROW) begin
                                out_row <= out_row + ROW_W'(1);
                                rd_en   <= 1'b1;
                                state   <= ST_READ;
                            end else begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
